// File: rtl/boot_loader.sv
// boot_loader: receives a framed program over a byte stream (A5, N, payload
// [, checksum]), writes it word by word into instruction RAM, then releases
// the CPU from reset until the CPU raises its halt flag.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the trailing checksum byte).
module boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  input  logic              cpu_halted,
  output logic              load_done,
  output logic              load_err
);
  localparam int BPW  = DATA_W / 8;
  localparam int BCW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MAXN = 2 ** ADDR_W;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, RUN, ERR} state_t;
`endif

  state_t            state, state_nx;
  logic [7:0]        left;      // words still to be received
  logic [ADDR_W-1:0] widx;      // address of the next word to write
  logic [BCW-1:0]    bcnt;      // byte position inside the current word
  logic [DATA_W-1:0] sh;        // partially assembled word
  logic [DATA_W+7:0] cat;
  logic              halt_q;
  logic              xfer, fin, word_done, halt_rise, len_bad;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign rx_ready  = !reset && (state != RUN);
  assign xfer      = rx_valid && rx_ready;
  assign cat       = {sh, rx_data};
  assign halt_rise = cpu_halted && !halt_q;
  assign len_bad   = (rx_data == 8'd0) || (int'(rx_data) > MAXN);
  // All words received but still in DATA: only the no-checksum build sits
  // here, for the cycle in which the final write strobe is out.
  assign fin       = (state == DATA) && (left == 8'd0);
  assign word_done = xfer && (state == DATA) && !fin && (bcnt == BCW'(BPW - 1));
  assign cpu_reset = reset || (state != RUN);
  assign load_done = !reset && (state == RUN);

  // Next-state logic for the load protocol.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ERR: if (xfer && rx_data == 8'hA5) state_nx = LEN;
      LEN:       if (xfer) state_nx = len_bad ? ERR : DATA;
`ifdef BOOT_CHECKSUM_EN
      // Leave on the last payload byte so a checksum byte arriving during
      // the final write strobe is taken by CSUM.
      DATA:      if (word_done && left == 8'd1) state_nx = CSUM;
      CSUM:      if (xfer) state_nx = (rx_data == csum) ? RUN : ERR;
`else
      DATA:      if (fin) state_nx = RUN;
`endif
      RUN:       if (halt_rise) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // State, assembly datapath, RAM write port and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      left      <= '0;
      widx      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      halt_q    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      load_err  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state  <= state_nx;
      halt_q <= cpu_halted;
      mem_we <= word_done;
      if (state == LEN && xfer) begin
        left <= rx_data;
        widx <= '0;
        bcnt <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == DATA && xfer && !fin) begin
        sh   <= cat[DATA_W-1:0];
        bcnt <= word_done ? '0 : bcnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
        csum <= csum + rx_data;
`endif
      end
      if (word_done) begin
        mem_addr  <= widx;
        mem_wdata <= cat[DATA_W-1:0];
        widx      <= widx + 1'b1;
        left      <= left - 8'd1;
      end
      if (state_nx == ERR && state != ERR)
        load_err <= 1'b1;
      else if ((state == IDLE || state == ERR) && xfer && rx_data == 8'hA5)
        load_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (ADDR_W=2 so the length limit is reachable).
// Expected RAM writes go into a scoreboard queue as bytes are sent; a monitor
// pops and compares on every write strobe.
module tb_boot_loader;
  logic        clk, reset, rx_valid, rx_ready, mem_we, cpu_reset, cpu_halted;
  logic        load_done, load_err;
  logic [7:0]  rx_data;
  logic [1:0]  mem_addr;
  logic [15:0] mem_wdata;

  typedef struct packed { logic [1:0] addr; logic [15:0] data; } wr_t;
  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;

  boot_loader #(.ADDR_W(2), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .cpu_halted(cpu_halted),
    .load_done(load_done), .load_err(load_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {14'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {14'd0, mem_addr, mem_wdata}, {14'd0, e.addr, e.data});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("send_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Full frame; checks that RUN is reached at the expected cycle.
  task automatic load(input int n, input logic [15:0] w0, w1, w2, w3);
    logic [15:0] w [4];
    logic [7:0]  sum;
    wr_t e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    sum = 8'd0;
    send(8'hA5);
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      e.addr = 2'(i);
      e.data = w[i];
      exp_q.push_back(e);
      send(w[i][15:8]);
      send(w[i][7:0]);
      sum = sum + w[i][15:8] + w[i][7:0];
    end
`ifdef BOOT_CHECKSUM_EN
    send(sum);
`else
    rx_valid = 1'b0;
    chk("run_not_before_write_cycle", 32'(load_done), 32'd0);
    @(negedge clk);
`endif
    rx_valid = 1'b0;
    chk("run_load_done", 32'(load_done), 32'd1);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_rx_ready", 32'(rx_ready), 32'd0);
    chk("run_load_err", 32'(load_err), 32'd0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

    // Two-word load.
    load(2, 16'h1234, 16'h5678, 16'h0, 16'h0);

    // Bytes offered in RUN are refused and change nothing.
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    chk("run_ignore_ready", 32'(rx_ready), 32'd0);
    chk("run_ignore_done", 32'(load_done), 32'd1);
    rx_valid = 1'b0;

    // Halt pulse returns to IDLE the next cycle.
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("halt_load_done", 32'(load_done), 32'd0);
    chk("halt_rx_ready", 32'(rx_ready), 32'd1);

    // Junk before header, then zero length.
    send(8'h00); send(8'hFF);
    chk("junk_no_err", 32'(load_err), 32'd0);
    send(8'hA5); send(8'h00);
    idle(1);
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h00);
    chk("err_ignores_junk", 32'(load_err), 32'd1);
    send(8'hA5);
    chk("a5_clears_err", 32'(load_err), 32'd0);
    send(8'h05);
    chk("len_over_err", 32'(load_err), 32'd1);

`ifdef BOOT_CHECKSUM_EN
    // Bad checksum: the word is still written, then ERR.
    begin
      wr_t e;
      e.addr = 2'd0; e.data = 16'hABCD;
      exp_q.push_back(e);
    end
    send(8'hA5); send(8'h01); send(8'hAB); send(8'hCD); send(8'h00);
    idle(1);
    chk("csum_bad_err", 32'(load_err), 32'd1);
    chk("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("csum_bad_done", 32'(load_done), 32'd0);
`endif

    // Maximum length (2^ADDR_W words) with the halt level held high.
    cpu_halted = 1'b1;
    load(4, 16'hBEEF, 16'h0102, 16'hFFFF, 16'h8000);
    idle(3);
    chk("halt_level_no_exit", 32'(load_done), 32'd1);
    cpu_halted = 1'b0;
    @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    chk("halt_edge_exit", 32'(load_done), 32'd0);

    // Reset in the middle of a load: no write may follow.
    send(8'hA5); send(8'h02); send(8'h12);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset_vals("midload_reset");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("after_reset_err", 32'(load_err), 32'd0);
    load(1, 16'h0001, 16'h0, 16'h0, 16'h0);
    idle(2);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
